// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: four-stage signed multiply-accumulate slice with a pre-adder,
// frame-based accumulation (dump and clear every ACC_LEN samples or on in_last) and optional saturation.
module dsp_mac_pipe #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int P_WIDTH  = 48,
    parameter int ACC_LEN  = 8,
    parameter int SATURATE = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CE,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [A_WIDTH-1:0]           A,
    input  logic [B_WIDTH-1:0]           B,
    input  logic [B_WIDTH-1:0]           D,
    input  logic [2:0]                   mode,
    output logic [A_WIDTH+B_WIDTH:0]     M,
    output logic [P_WIDTH-1:0]           P,
    output logic                         out_valid,
    output logic                         ovf,
    output logic [$clog2(ACC_LEN+1)-1:0] acc_cnt
);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;
    localparam int CNT_W   = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(ACC_LEN - 1);
    localparam logic [P_WIDTH-1:0] P_MAX    = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] P_MIN    = {1'b1, {(P_WIDTH-1){1'b0}}};

    logic [A_WIDTH-1:0]        a1;
    logic [B_WIDTH-1:0]        b1;
    logic [B_WIDTH-1:0]        d1;
    logic [2:0]                mode1;
    logic                      last1;
    logic                      valid1;

    logic signed [A_WIDTH-1:0] a2;
    logic signed [B_WIDTH:0]   pb2;
    logic                      sub2;
    logic                      last2;
    logic                      valid2;

    logic                      sub3;
    logic                      last3;
    logic                      valid3;

    logic [P_WIDTH-1:0]        acc;
    logic                      ovf_acc;

    logic signed [B_WIDTH:0]   b_ext;
    logic signed [B_WIDTH:0]   d_ext;
    logic signed [B_WIDTH:0]   pb_next;
    logic signed [P_WIDTH-1:0] m_ext;
    logic signed [P_WIDTH-1:0] term;
    logic [P_WIDTH:0]          sum;
    logic                      sum_ovf;
    logic [P_WIDTH-1:0]        result;
    logic                      dump;

    always_comb begin
        b_ext   = {b1[B_WIDTH-1], b1};
        d_ext   = {d1[B_WIDTH-1], d1};
        pb_next = b_ext;
        if (mode1[0]) begin
            pb_next = mode1[1] ? (d_ext - b_ext) : (d_ext + b_ext);
        end
    end

    // One guard bit above the accumulator: overflow shows as the top two sum bits disagreeing.
    always_comb begin
        m_ext   = P_WIDTH'($signed(M));
        term    = sub3 ? -m_ext : m_ext;
        sum     = {acc[P_WIDTH-1], acc} + {term[P_WIDTH-1], term};
        sum_ovf = sum[P_WIDTH] ^ sum[P_WIDTH-1];
        result  = sum[P_WIDTH-1:0];
        if (sum_ovf && (SATURATE != 0)) begin
            result = sum[P_WIDTH] ? P_MIN : P_MAX;
        end
        dump = valid3 && ((acc_cnt == LAST_CNT) || last3);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a1     <= '0;
            b1     <= '0;
            d1     <= '0;
            mode1  <= '0;
            last1  <= 1'b0;
            valid1 <= 1'b0;
            a2     <= '0;
            pb2    <= '0;
            sub2   <= 1'b0;
            last2  <= 1'b0;
            valid2 <= 1'b0;
            M      <= '0;
            sub3   <= 1'b0;
            last3  <= 1'b0;
            valid3 <= 1'b0;
        end else if (CE) begin
            a1     <= A;
            b1     <= B;
            d1     <= D;
            mode1  <= mode;
            last1  <= in_last;
            valid1 <= in_valid;
            a2     <= $signed(a1);
            pb2    <= pb_next;
            sub2   <= mode1[2];
            last2  <= last1;
            valid2 <= valid1;
            M      <= M_WIDTH'(a2) * M_WIDTH'(pb2);
            sub3   <= sub2;
            last3  <= last2;
            valid3 <= valid2;
        end
    end

    // out_valid is the only register that moves while CE is low: it always drops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            acc_cnt   <= '0;
            P         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= CE && dump;
            if (CE && valid3) begin
                if (dump) begin
                    P       <= result;
                    ovf     <= ovf_acc | sum_ovf;
                    acc     <= '0;
                    ovf_acc <= 1'b0;
                    acc_cnt <= '0;
                end else begin
                    acc     <= result;
                    ovf_acc <= ovf_acc | sum_ovf;
                    acc_cnt <= acc_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: three slices (48-bit ACC_LEN=4, and 17-bit ACC_LEN=8 saturating/wrapping)
// driven in lockstep and compared against a frame-level arithmetic model.
module tb_dsp_mac_pipe;
    logic        CLK = 1'b0;
    logic        RST;
    logic        CE;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  mode;
    logic [17:0] a_big, b_big, d_big;
    logic [7:0]  a_sml, b_sml, d_sml;

    logic [36:0] m_big;
    logic [47:0] p_big;
    logic        ov_big, ovf_big;
    logic [2:0]  cnt_big;
    logic [16:0] m_s1, p_s1, m_s0, p_s0;
    logic        ov_s1, ovf_s1, ov_s0, ovf_s0;
    logic [3:0]  cnt_s1, cnt_s0;

    int n_checks = 0;
    int n_fail   = 0;

    dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .ACC_LEN(4), .SATURATE(1)) u_big (
        .CLK(CLK), .RST(RST), .CE(CE), .in_valid(in_valid), .in_last(in_last),
        .A(a_big), .B(b_big), .D(d_big), .mode(mode),
        .M(m_big), .P(p_big), .out_valid(ov_big), .ovf(ovf_big), .acc_cnt(cnt_big));

    dsp_mac_pipe #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(17), .ACC_LEN(8), .SATURATE(1)) u_s1 (
        .CLK(CLK), .RST(RST), .CE(CE), .in_valid(in_valid), .in_last(in_last),
        .A(a_sml), .B(b_sml), .D(d_sml), .mode(mode),
        .M(m_s1), .P(p_s1), .out_valid(ov_s1), .ovf(ovf_s1), .acc_cnt(cnt_s1));

    dsp_mac_pipe #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(17), .ACC_LEN(8), .SATURATE(0)) u_s0 (
        .CLK(CLK), .RST(RST), .CE(CE), .in_valid(in_valid), .in_last(in_last),
        .A(a_sml), .B(b_sml), .D(d_sml), .mode(mode),
        .M(m_s0), .P(p_s0), .out_valid(ov_s0), .ovf(ovf_s0), .acc_cnt(cnt_s0));

    always #5 CLK = ~CLK;

    // Reference model: whole frames summed with plain integer arithmetic, each result
    // released three enabled clocks after its closing sample was captured.
    typedef struct {
        int     id;
        longint p;
        bit     ovf;
        int     due;
    } res_t;

    res_t   pend[$];
    longint macc[3];
    int     mcnt[3];
    bit     movf[3];
    longint exp_p[3];
    bit     exp_ovf[3];
    bit     exp_ov[3];
    int     ce_cycles = 0;

    function automatic longint fold(input longint s, input int pw, input bit sat, output bit o);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (pw - 1)) - 1;
        lo = -(longint'(1) <<< (pw - 1));
        o  = (s > hi) || (s < lo);
        if (!o) return s;
        if (sat) return (s > hi) ? hi : lo;
        return (s > hi) ? s - (longint'(1) <<< pw) : s + (longint'(1) <<< pw);
    endfunction

    always @(posedge CLK or posedge RST) begin : model
        longint a, b, d, pb, term, s;
        bit     o;
        int     pw, len;
        bit     sat;
        if (RST) begin
            pend.delete();
            for (int i = 0; i < 3; i++) begin
                macc[i] = 0; mcnt[i] = 0; movf[i] = 0;
                exp_p[i] = 0; exp_ovf[i] = 0; exp_ov[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) exp_ov[i] = 0;
            if (CE) begin
                ce_cycles++;
                for (int k = pend.size() - 1; k >= 0; k--) begin
                    if (pend[k].due == ce_cycles) begin
                        exp_p[pend[k].id]   = pend[k].p;
                        exp_ovf[pend[k].id] = pend[k].ovf;
                        exp_ov[pend[k].id]  = 1'b1;
                        pend.delete(k);
                    end
                end
                if (in_valid) begin
                    for (int i = 0; i < 3; i++) begin
                        if (i == 0) begin
                            a = $signed(a_big); b = $signed(b_big); d = $signed(d_big);
                            pw = 48; len = 4; sat = 1'b1;
                        end else begin
                            a = $signed(a_sml); b = $signed(b_sml); d = $signed(d_sml);
                            pw = 17; len = 8; sat = (i == 1);
                        end
                        pb   = mode[0] ? (mode[1] ? d - b : d + b) : b;
                        term = a * pb;
                        if (mode[2]) term = -term;
                        s = fold(macc[i] + term, pw, sat, o);
                        movf[i] = movf[i] | o;
                        mcnt[i]++;
                        if (mcnt[i] == len || in_last) begin
                            pend.push_back('{i, s, movf[i], ce_cycles + 3});
                            macc[i] = 0; mcnt[i] = 0; movf[i] = 0;
                        end else begin
                            macc[i] = s;
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input bit ce, input bit v, input bit last, input logic [2:0] md,
                         input int a, input int b, input int d);
        CE = ce; in_valid = v; in_last = last; mode = md;
        a_big = 18'(a); b_big = 18'(b); d_big = 18'(d);
        a_sml = 8'(a);  b_sml = 8'(b);  d_sml = 8'(d);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(1, 0, 0, 3'b000, 0, 0, 0);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; CE = 1'b1; in_valid = 1'b0; in_last = 1'b0; mode = 3'b000;
        a_big = '0; b_big = '0; d_big = '0; a_sml = '0; b_sml = '0; d_sml = '0;
        #1;
        n_checks++; if (p_big !== 48'd0)  begin n_fail++; $display("[TB] FAIL reset_p got=%0h exp=0", p_big); end
        n_checks++; if (m_big !== 37'd0)  begin n_fail++; $display("[TB] FAIL reset_m got=%0h exp=0", m_big); end
        n_checks++; if (ov_big !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_out_valid got=%b exp=0", ov_big); end
        n_checks++; if (ovf_big !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf_big); end
        n_checks++; if (cnt_big !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_acc_cnt got=%0d exp=0", cnt_big); end
        n_checks++; if (p_s0 !== 17'd0)   begin n_fail++; $display("[TB] FAIL reset_p_s0 got=%0h exp=0", p_s0); end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic_frame();
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive(1, cyc < 4, 0, 3'b000, 2, 3, 0);
            if (cyc == 2) begin
                n_checks++; if (m_big !== 37'd6) begin n_fail++; $display("[TB] FAIL basic_m got=%0d exp=6", m_big); end
            end
            n_checks++;
            if (ov_big !== (cyc == 6)) begin n_fail++; $display("[TB] FAIL basic_out_valid cyc=%0d got=%b exp=%b", cyc, ov_big, cyc == 6); end
            if (cyc == 6) begin
                n_checks++; if (p_big !== 48'd24) begin n_fail++; $display("[TB] FAIL basic_p got=%0d exp=24", p_big); end
                n_checks++; if (ovf_big !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ovf got=%b exp=0", ovf_big); end
            end
        end
        n_checks++; if (cnt_big !== 3'd0) begin n_fail++; $display("[TB] FAIL basic_acc_cnt got=%0d exp=0", cnt_big); end
    endtask

    task automatic test_preadder_sub();
        do_reset();
        drive(1, 1, 0, 3'b011, 5, 4, 10);
        drive(1, 1, 1, 3'b100, 3, -7, 0);
        drive(1, 0, 0, 3'b000, 0, 0, 0);
        n_checks++; if (m_big !== 37'd30) begin n_fail++; $display("[TB] FAIL preadd_m got=%0d exp=30", m_big); end
        drive(1, 0, 0, 3'b000, 0, 0, 0);
        n_checks++; if (ov_big !== 1'b0) begin n_fail++; $display("[TB] FAIL preadd_early_valid got=%b exp=0", ov_big); end
        drive(1, 0, 0, 3'b000, 0, 0, 0);
        n_checks++; if (ov_big !== 1'b1)  begin n_fail++; $display("[TB] FAIL preadd_out_valid got=%b exp=1", ov_big); end
        n_checks++; if (p_big !== 48'd51) begin n_fail++; $display("[TB] FAIL preadd_p got=%0d exp=51", $signed(p_big)); end
        n_checks++; if (p_s1 !== 17'd51)  begin n_fail++; $display("[TB] FAIL preadd_p_small got=%0d exp=51", $signed(p_s1)); end
        drive(1, 0, 0, 3'b000, 0, 0, 0);
        n_checks++; if (ov_big !== 1'b0) begin n_fail++; $display("[TB] FAIL preadd_pulse_width got=%b exp=0", ov_big); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int frame = 0; frame < 2; frame++) begin
            for (int cyc = 0; cyc < 12; cyc++) begin
                drive(1, cyc < 8, 0, 3'b000, (frame == 0) ? 127 : 1, (frame == 0) ? 127 : 1, 0);
                if (cyc == 10) begin
                    n_checks++; if (ov_s1 !== 1'b1 || ov_s0 !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_out_valid frame=%0d got=%b%b exp=11", frame, ov_s1, ov_s0); end
                    if (frame == 0) begin
                        n_checks++; if (p_s1 !== 17'd65535)   begin n_fail++; $display("[TB] FAIL sat_clamp_p got=%0d exp=65535", $signed(p_s1)); end
                        n_checks++; if (ovf_s1 !== 1'b1)      begin n_fail++; $display("[TB] FAIL sat_clamp_ovf got=%b exp=1", ovf_s1); end
                        n_checks++; if (p_s0 !== 17'h1F808)   begin n_fail++; $display("[TB] FAIL sat_wrap_p got=%0d exp=-2040", $signed(p_s0)); end
                        n_checks++; if (ovf_s0 !== 1'b1)      begin n_fail++; $display("[TB] FAIL sat_wrap_ovf got=%b exp=1", ovf_s0); end
                    end else begin
                        n_checks++; if (p_s1 !== 17'd8 || p_s0 !== 17'd8)     begin n_fail++; $display("[TB] FAIL sat_clean_p got=%0d/%0d exp=8", p_s1, p_s0); end
                        n_checks++; if (ovf_s1 !== 1'b0 || ovf_s0 !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_clean_ovf got=%b%b exp=00", ovf_s1, ovf_s0); end
                    end
                end
            end
        end
    endtask

    task automatic test_early_last();
        int pulses;
        pulses = 0;
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(1, (cyc == 0) || (cyc == 2) || (cyc == 5), cyc == 5, 3'b000, 1, 1, 0);
            if (ov_s1 === 1'b1) pulses++;
            if (cyc == 8) begin
                n_checks++; if (ov_s1 !== 1'b1) begin n_fail++; $display("[TB] FAIL last_out_valid got=%b exp=1", ov_s1); end
                n_checks++; if (p_s1 !== 17'd3) begin n_fail++; $display("[TB] FAIL last_p got=%0d exp=3", p_s1); end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("[TB] FAIL last_pulse_count got=%0d exp=1", pulses); end
        drive(1, 1, 0, 3'b000, 1, 1, 0);
        for (int cyc = 0; cyc < 3; cyc++) drive(1, 0, 0, 3'b000, 0, 0, 0);
        n_checks++; if (cnt_s1 !== 4'd1) begin n_fail++; $display("[TB] FAIL last_next_cnt got=%0d exp=1", cnt_s1); end
    endtask

    task automatic test_ce_stall_reset();
        bit ce;
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            ce = !((cyc >= 2) && (cyc <= 4));
            drive(ce, cyc < 7, 0, 3'b000, ce ? 1 : 100, 1, 0);
            n_checks++;
            if (ov_big !== (cyc == 9)) begin n_fail++; $display("[TB] FAIL stall_out_valid cyc=%0d got=%b exp=%b", cyc, ov_big, cyc == 9); end
        end
        n_checks++; if (p_big !== 48'd4) begin n_fail++; $display("[TB] FAIL stall_p got=%0d exp=4", p_big); end
        for (int cyc = 0; cyc < 3; cyc++) drive(1, 1, 0, 3'b000, 1, 1, 0);
        drive(1, 0, 0, 3'b000, 0, 0, 0);
        #2 RST = 1'b1;
        #1;
        n_checks++; if (p_big !== 48'd0)  begin n_fail++; $display("[TB] FAIL rst_mid_p got=%0d exp=0", p_big); end
        n_checks++; if (cnt_big !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_mid_acc_cnt got=%0d exp=0", cnt_big); end
        @(negedge CLK);
        RST = 1'b0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            drive(1, (cyc >= 4) && (cyc < 8), 0, 3'b000, 1, 1, 0);
            n_checks++;
            if (ov_big !== (cyc == 10)) begin n_fail++; $display("[TB] FAIL rst_out_valid cyc=%0d got=%b exp=%b", cyc, ov_big, cyc == 10); end
        end
        n_checks++; if (p_big !== 48'd4) begin n_fail++; $display("[TB] FAIL rst_new_frame_p got=%0d exp=4", p_big); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  3'($urandom_range(0, 7)), int'($urandom), int'($urandom), int'($urandom));
            n_checks++; if (ov_big !== exp_ov[0])         begin n_fail++; $display("[TB] FAIL rand_ov_big cyc=%0d got=%b exp=%b", cyc, ov_big, exp_ov[0]); end
            n_checks++; if (p_big !== exp_p[0][47:0])     begin n_fail++; $display("[TB] FAIL rand_p_big cyc=%0d got=%0h exp=%0h", cyc, p_big, exp_p[0][47:0]); end
            n_checks++; if (ovf_big !== exp_ovf[0])       begin n_fail++; $display("[TB] FAIL rand_ovf_big cyc=%0d got=%b exp=%b", cyc, ovf_big, exp_ovf[0]); end
            n_checks++; if (ov_s1 !== exp_ov[1])          begin n_fail++; $display("[TB] FAIL rand_ov_s1 cyc=%0d got=%b exp=%b", cyc, ov_s1, exp_ov[1]); end
            n_checks++; if (p_s1 !== exp_p[1][16:0])      begin n_fail++; $display("[TB] FAIL rand_p_s1 cyc=%0d got=%0h exp=%0h", cyc, p_s1, exp_p[1][16:0]); end
            n_checks++; if (ovf_s1 !== exp_ovf[1])        begin n_fail++; $display("[TB] FAIL rand_ovf_s1 cyc=%0d got=%b exp=%b", cyc, ovf_s1, exp_ovf[1]); end
            n_checks++; if (ov_s0 !== exp_ov[2])          begin n_fail++; $display("[TB] FAIL rand_ov_s0 cyc=%0d got=%b exp=%b", cyc, ov_s0, exp_ov[2]); end
            n_checks++; if (p_s0 !== exp_p[2][16:0])      begin n_fail++; $display("[TB] FAIL rand_p_s0 cyc=%0d got=%0h exp=%0h", cyc, p_s0, exp_p[2][16:0]); end
            n_checks++; if (ovf_s0 !== exp_ovf[2])        begin n_fail++; $display("[TB] FAIL rand_ovf_s0 cyc=%0d got=%b exp=%b", cyc, ovf_s0, exp_ovf[2]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_preadder_sub();
        test_saturation();
        test_early_last();
        test_ce_stall_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
